// File: rtl/vc_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vc_scheduler_pkg
//    Shared transaction-layer definitions used by the virtual-channel
//    scheduler: number of classes, data width, power-up FSM state encodings
//    and the class encodings 0..3.
//    No ports (package only).
// ---------------------------------------------------------------------------
package vc_scheduler_pkg;

   localparam int TL_NUM_VC = 4;
   localparam int TL_DATA_W = 12;

   // Power-up FSM state encodings (one-hot style, OFF is all zero)
   localparam logic [3:0] TL_ST_OFF    = 4'b0000;
   localparam logic [3:0] TL_ST_PWRUP  = 4'b0001;
   localparam logic [3:0] TL_ST_INIT   = 4'b0010;
   localparam logic [3:0] TL_ST_ACTIVE = 4'b0100;
   localparam logic [3:0] TL_ST_ERROR  = 4'b1000;

   // Virtual-channel class encodings
   typedef enum logic [1:0] {
      VC_CLASS0 = 2'd0,
      VC_CLASS1 = 2'd1,
      VC_CLASS2 = 2'd2,
      VC_CLASS3 = 2'd3
   } vcClass_t;

   // Class that follows vc in round-robin order, wrapping 3 -> 0
   function automatic logic [1:0] nextVc(input logic [1:0] vc);
      return vc + 2'd1;
   endfunction

endpackage

// File: rtl/vc_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//    Purely combinational rotate-priority picker for four requesters.
//    The scan starts at ptr and proceeds ptr+1, ptr+2, ptr+3 (mod 4); the
//    first requester found wins.
//    Ports:
//       req     - request vector, one bit per class
//       ptr     - class with highest priority this cycle
//       gnt     - one-hot grant (all zero when nothing requests)
//       gnt_idx - index of the granted class (0 when nothing requests)
//       any     - at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
   import vc_scheduler_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       any
);

   logic [1:0] scanIdx;

   // Walk the four positions starting at the pointer. Once a winner is
   // found the 'any' flag masks every later position, which keeps the
   // grant one-hot by construction.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      scanIdx = ptr;
      for (int k = 0; k < TL_NUM_VC; k++) begin
         scanIdx = ptr + 2'(k);
         if (!any && req[scanIdx]) begin
            any          = 1'b1;
            gnt_idx      = scanIdx;
            gnt[scanIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vc_scheduler.sv
// ---------------------------------------------------------------------------
// vc_scheduler
//    Round-robin scheduler for the four virtual-channel input FIFOs. Each
//    cycle it pops at most one eligible input FIFO, and one cycle later
//    pushes the popped word into the shared output FIFO with the matching
//    mux select and class tag. A class may receive up to MAX_BURST
//    consecutive grants before the priority pointer moves on.
//    Ports:
//       clk          - clock, rising edge
//       reset        - synchronous reset, active high
//       state        - power-up FSM state; traffic only in ST_ACTIVE
//       empty_in     - empty flags of input FIFOs 0..3
//       alm_full_out - almost-full flags of per-class output FIFOs 0..3
//       mid_alm_full - almost-full flag of the shared output FIFO
//       pop          - one-hot pop to input FIFOs (combinational)
//       push         - push to shared output FIFO (registered)
//       sel          - mux select aligned with push (registered)
//       class_out    - class tag aligned with push (registered)
//       idle         - nothing popped, nothing pending, all inputs empty
// ---------------------------------------------------------------------------
module vc_scheduler
   import vc_scheduler_pkg::*;
#(
   parameter int         NUM_VC    = TL_NUM_VC,
   parameter int         MAX_BURST = 1,
   parameter logic [3:0] ST_ACTIVE = TL_ST_ACTIVE
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        state,
   input  logic [NUM_VC-1:0] empty_in,
   input  logic [NUM_VC-1:0] alm_full_out,
   input  logic              mid_alm_full,
   output logic [NUM_VC-1:0] pop,
   output logic              push,
   output logic [1:0]        sel,
   output logic [1:0]        class_out,
   output logic              idle
);

   logic              act;
   logic [NUM_VC-1:0] elig;
   logic [NUM_VC-1:0] gnt;
   logic [1:0]        gntIdx;
   logic              anyElig;
   logic              grant;
   logic [3:0]        nextCnt;

   logic [1:0] ptr_q,      ptr_d;
   logic [2:0] burstCnt_q, burstCnt_d;
   logic       pendV_q,    pendV_d;
   vcClass_t   pendVc_q,   pendVc_d;

   // A class may be popped only while the link is active, its input FIFO
   // holds data and both the shared and its own output FIFO have room.
   always_comb begin
      act  = (state == ST_ACTIVE);
      elig = {NUM_VC{act & ~mid_alm_full}} & ~empty_in & ~alm_full_out;
   end

   rr_pick u_pick (
      .req     (elig),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gntIdx),
      .any     (anyElig)
   );

   // Reset suppresses the pop combinationally so no word leaves an input
   // FIFO whose push would be discarded by the reset anyway.
   always_comb begin
      grant = anyElig & ~reset;
      pop   = grant ? gnt : '0;
   end

   // Next-state for pointer, burst counter and pending push. A grant to a
   // class other than the pointer restarts the burst count at one; hitting
   // the burst limit hands priority to the class after the winner.
   always_comb begin
      ptr_d      = ptr_q;
      burstCnt_d = burstCnt_q;
      pendV_d    = 1'b0;
      pendVc_d   = pendVc_q;
      nextCnt    = (gntIdx == ptr_q) ? ({1'b0, burstCnt_q} + 4'd1) : 4'd1;
      if (grant) begin
         pendV_d  = 1'b1;
         pendVc_d = vcClass_t'(gntIdx);
         if (nextCnt >= 4'(MAX_BURST)) begin
            ptr_d      = nextVc(gntIdx);
            burstCnt_d = 3'd0;
         end else begin
            ptr_d      = gntIdx;
            burstCnt_d = nextCnt[2:0];
         end
      end
   end

   // State registers with synchronous reset back to class 0 priority and no
   // pending push.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= 2'd0;
         burstCnt_q <= 3'd0;
         pendV_q    <= 1'b0;
         pendVc_q   <= VC_CLASS0;
      end else begin
         ptr_q      <= ptr_d;
         burstCnt_q <= burstCnt_d;
         pendV_q    <= pendV_d;
         pendVc_q   <= pendVc_d;
      end
   end

   // The push side is driven straight from the pending registers, so push,
   // sel and class_out line up with the data the input FIFO presents one
   // cycle after the pop.
   always_comb begin
      push      = pendV_q;
      sel       = pendVc_q;
      class_out = pendVc_q;
      idle      = ~|pop & ~pendV_q & &empty_in;
   end

endmodule

// File: tb/tb_vc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vc_scheduler
//    Directed bench for vc_scheduler. Two instances are built, one with
//    MAX_BURST=1 and one with MAX_BURST=2, sharing all inputs. Stimulus
//    pushes the hand-computed class of each expected pop into a queue; a
//    monitor running on the falling edge pops that queue whenever the
//    watched instance pops, and checks that every push follows its pop one
//    cycle later with matching sel and class_out.
// ---------------------------------------------------------------------------
module tb_vc_scheduler;

   localparam logic [3:0] ACT   = 4'b0100;
   localparam logic [3:0] INACT = 4'b0001;
   localparam logic [3:0] ALL_E = 4'b1111;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] state;
   logic [3:0] emptyIn;
   logic [3:0] almFullOut;
   logic       midAlmFull;

   logic [3:0] pop1, pop2;
   logic       push1, push2;
   logic [1:0] sel1, sel2, cls1, cls2;
   logic       idle1, idle2;

   int checks = 0;
   int errors = 0;
   int dutSel = 1;
   int expQ[$];

   // 100 MHz style clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   vc_scheduler #(.MAX_BURST(1)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .state        (state),
      .empty_in     (emptyIn),
      .alm_full_out (almFullOut),
      .mid_alm_full (midAlmFull),
      .pop          (pop1),
      .push         (push1),
      .sel          (sel1),
      .class_out    (cls1),
      .idle         (idle1)
   );

   vc_scheduler #(.MAX_BURST(2)) dut2 (
      .clk          (clk),
      .reset        (reset),
      .state        (state),
      .empty_in     (emptyIn),
      .alm_full_out (almFullOut),
      .mid_alm_full (midAlmFull),
      .pop          (pop2),
      .push         (push2),
      .sel          (sel2),
      .class_out    (cls2),
      .idle         (idle2)
   );

   // Compare one observed value with its expected value and log failures
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, record the
   // expected pop class (-1 for none), then wait until just after the
   // falling edge so callers can inspect outputs.
   task automatic applyStimulus(input logic rst, input logic [3:0] st,
                                input logic [3:0] emp, input logic [3:0] alm,
                                input logic mid, input int expW);
      @(posedge clk);
      #1;
      reset      = rst;
      state      = st;
      emptyIn    = emp;
      almFullOut = alm;
      midAlmFull = mid;
      if (expW >= 0) expQ.push_back(expW);
      @(negedge clk);
      #1;
   endtask

   // Two reset cycles with idle inputs; the watched instance is switched
   // between them, when both pop outputs are forced low.
   task automatic applyReset(input int which);
      applyStimulus(1'b1, ACT, ALL_E, 4'b0000, 1'b0, -1);
      dutSel = which;
      applyStimulus(1'b1, ACT, ALL_E, 4'b0000, 1'b0, -1);
   endtask

   // Let outstanding pushes drain, then confirm every expected pop occurred
   task automatic flushCheck(input string name);
      applyStimulus(1'b0, ACT, ALL_E, 4'b0000, 1'b0, -1);
      applyStimulus(1'b0, ACT, ALL_E, 4'b0000, 1'b0, -1);
      checkOutput(name, expQ.size(), 0);
      expQ.delete();
   endtask

   // Monitor: scoreboards pops against the queue, checks one-hot, and
   // checks that push/sel/class_out follow the previous cycle's pop.
   initial begin
      logic [3:0] mPop;
      logic       mPush;
      logic [1:0] mSel, mCls;
      logic       prevAny;
      int         prevIdx;
      int         w;
      prevAny = 1'b0;
      prevIdx = 0;
      forever begin
         @(negedge clk);
         mPop  = (dutSel == 2) ? pop2  : pop1;
         mPush = (dutSel == 2) ? push2 : push1;
         mSel  = (dutSel == 2) ? sel2  : sel1;
         mCls  = (dutSel == 2) ? cls2  : cls1;
         checkOutput("popOneHot", int'($countones(mPop) <= 1), 1);
         if (mPop != 4'b0000) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedPop", int'(mPop), 0);
            end else begin
               w = expQ.pop_front();
               checkOutput("popClass", int'(mPop), 1 << w);
            end
         end
         checkOutput("pushLag", int'(mPush), int'(prevAny));
         if (prevAny) begin
            checkOutput("selLag", int'(mSel), prevIdx);
            checkOutput("classLag", int'(mCls), prevIdx);
         end
         prevAny = |mPop;
         for (int i = 0; i < 4; i++) if (mPop[i]) prevIdx = i;
      end
   end

   // Hard bound on total runtime
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rrSeq[6]      = '{0, 1, 2, 3, 0, 1};
      int burstSeq[9]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      int burstSkip[6]  = '{0, 0, 2, 2, 3, 3};
      int almSeq[6]     = '{0, 1, 3, 0, 1, 3};

      reset      = 1'b1;
      state      = ACT;
      emptyIn    = ALL_E;
      almFullOut = 4'b0000;
      midAlmFull = 1'b0;

      // Reset and static behaviour
      $display("[TB] reset and static checks");
      applyReset(1);
      applyStimulus(1'b1, ACT, 4'b0000, 4'b0000, 1'b0, -1);
      checkOutput("resetPop1", int'(pop1), 0);
      checkOutput("resetPop2", int'(pop2), 0);
      applyStimulus(1'b0, ACT, ALL_E, 4'b0000, 1'b0, -1);
      checkOutput("rstPop", int'(pop1), 0);
      checkOutput("rstPush", int'(push1), 0);
      checkOutput("rstIdle", int'(idle1), 1);
      checkOutput("rstSel", int'(sel1), 0);
      checkOutput("rstClass", int'(cls1), 0);
      checkOutput("rstIdle2", int'(idle2), 1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, INACT, 4'b0000, 4'b0000, 1'b0, -1);
         checkOutput("inactivePop1", int'(pop1), 0);
         checkOutput("inactivePop2", int'(pop2), 0);
      end
      flushCheck("staticDrain");

      // Pure round robin
      $display("[TB] round robin, MAX_BURST=1");
      applyReset(1);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, rrSeq[i]);
      flushCheck("rrDrain");

      // Bursts of two
      $display("[TB] bursts, MAX_BURST=2");
      applyReset(2);
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, burstSeq[i]);
      flushCheck("burstDrain");

      $display("[TB] bursts with class 1 empty");
      applyReset(2);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, ACT, 4'b0010, 4'b0000, 1'b0, burstSkip[i]);
      flushCheck("burstSkipDrain");

      // Per-class back-pressure on class 2
      $display("[TB] alm_full_out[2] back-pressure");
      applyReset(1);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, ACT, 4'b0000, 4'b0100, 1'b0, almSeq[i]);
      flushCheck("almDrain");

      // Shared FIFO back-pressure: pending push still lands
      $display("[TB] mid_alm_full back-pressure");
      applyReset(1);
      applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, 0);
      applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b1, -1);
      checkOutput("midPop", int'(pop1), 0);
      checkOutput("midPush", int'(push1), 1);
      checkOutput("midSel", int'(sel1), 0);
      applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, 1);
      flushCheck("midDrain");

      // Reset in the cycle after pop[1]
      $display("[TB] reset mid-operation");
      applyReset(1);
      applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, 0);
      applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, 1);
      applyStimulus(1'b1, ACT, 4'b0000, 4'b0000, 1'b0, -1);
      checkOutput("midRstPop", int'(pop1), 0);
      checkOutput("midRstPendPush", int'(push1), 1);
      applyStimulus(1'b0, ACT, 4'b0000, 4'b0000, 1'b0, 0);
      checkOutput("postRstPush", int'(push1), 0);
      checkOutput("postRstPop", int'(pop1), 1);
      flushCheck("rstDrain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vc_scheduler.md
# vc_scheduler

Round-robin scheduler for the four virtual-channel input FIFOs (classes 0–3) of the transaction layer. It decides which input FIFO is popped each cycle and drives the mux select and the push of the shared output FIFO. Each class has a bounded burst length. The block gates on the power-up FSM state and on back-pressure from both the shared FIFO and the per-class output FIFOs. It replaces the free-running pop logic between the input FIFOs, the mux and the output FIFO.

## Interface
- `NUM_VC`, 4: number of classes. The RTL is written for exactly 4.
- `MAX_BURST`, 1: maximum consecutive grants to one class before the pointer advances. Legal range is 1..7.
- `ST_ACTIVE`, 4'b0100: the FSM `state` encoding in which traffic is allowed.
- `clk`, in, 1: the single clock. All logic is clocked on the rising edge.
- `reset`, in, 1: synchronous reset, active-high.
- `state`, in, 4: current state of the power-up FSM.
- `empty_in`, in, 4: empty flags of input FIFOs 0..3.
- `alm_full_out`, in, 4: almost-full flags of the per-class output FIFOs 0..3.
- `mid_alm_full`, in, 1: almost-full flag of the shared output FIFO that feeds the output demux.
- `pop`, out, 4: one-hot pop to input FIFOs 0..3. Combinational.
- `push`, out, 1: push to the shared output FIFO. Registered.
- `sel`, out, 2: mux select, aligned with `push`. Registered.
- `class_out`, out, 2: class tag for the output demux, aligned with `push`. Registered.
- `idle`, out, 1: no traffic pending.

## Operation
- Eligibility:
  - `act = (state == ST_ACTIVE)`.
  - `elig[i] = act & ~empty_in[i] & ~alm_full_out[i] & ~mid_alm_full`.
- Internal registers:
  - `ptr[1:0]`: preferred class.
  - `burst_cnt[2:0]`: grants already given to `ptr` in the current burst.
  - `pend_v`: a push is pending for the next cycle.
  - `pend_vc[1:0]`: class of that pending push.
- Winner selection:
  - `w` is the first `i` with `elig[i]`, scanning `ptr`, `ptr+1`, … modulo 4.
  - If no class is eligible, there is no grant.
- On a grant:
  - `pop[w]=1`, `pend_v<=1`, `pend_vc<=w`.
  - `n = (w==ptr) ? burst_cnt+1 : 1`.
  - If `n >= MAX_BURST`: `ptr<=w+1` (wraps 3→0) and `burst_cnt<=0`.
  - Otherwise: `ptr<=w` and `burst_cnt<=n`.
- With no grant: `pop=0`, `pend_v<=0`, and `ptr` and `burst_cnt` hold.
- Registered outputs follow the pending registers: `push=pend_v`, `sel=pend_vc`, `class_out=pend_vc`.
- `idle = ~|pop & ~pend_v & &empty_in`.
- At most one `pop` bit is high in any cycle (one-hot or zero).

## Timing
- Reset (`reset=1` at an edge):
  - At that edge: `ptr=0`, `burst_cnt=0`, `pend_v=0`, `pend_vc=0`.
  - From the following cycle: `push=0`, `sel=0`, `class_out=0`.
  - `pop` is forced to 0 combinationally while `reset=1`.
  - A word popped in the cycle before reset is dropped. All FIFOs are reset together, so this is acceptable.
- Latency: a grant in cycle N gives `pop[w]=1` in N. The input FIFO data is valid in N+1, when `push=1`, `sel=w` and `class_out=w` are also presented.
- Throughput: one grant per cycle, back-to-back, for as long as classes stay eligible.
- `state` leaving `ST_ACTIVE` in cycle N: no pop in N. A push already pending from N-1 still completes in N.
- An almost-full flag rising in cycle N blocks the pop in N. An in-flight push still lands, and the almost-full margin absorbs it.
- An empty flag and an almost-full flag changing in the same cycle are both evaluated combinationally in that cycle.
- When the `ptr` class becomes ineligible mid-burst, the scan skips it. The burst restarts at the winner with `n=1`.
- `MAX_BURST=1` gives pure round robin.

## Structure
- Shared include `tl_defs.vh` holds:
  - `ST_ACTIVE` and the other FSM state encodings.
  - `NUM_VC` and the data width (12).
  - The class encodings 0..3.
- Sub-module `rr_pick`: purely combinational rotate-priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `gnt[3:0]` (one-hot), `gnt_idx[1:0]`, `any`.
- `vc_scheduler` holds the pointer, burst counter and pending registers.

## Test plan
- Reset and static checks:
  - After reset, with `state=ST_ACTIVE` and all inputs empty: `pop=0`, `push=0`, `idle=1`, `sel=0`, `class_out=0`.
  - While `state≠ST_ACTIVE`, with all classes non-empty: `pop=0` for 20 cycles.
- Round robin: `MAX_BURST=1`, all four non-empty, no back-pressure → pop order 0,1,2,3,0,1 on consecutive cycles. Each `push` lags its pop by one cycle with matching `sel`/`class_out`.
- Burst: `MAX_BURST=2`, all non-empty → pop order 0,0,1,1,2,2,3,3,0. With class 1 empty mid-sequence → 0,0,2,2,3,3.
- Back-pressure:
  - `alm_full_out[2]=1` → class 2 is never popped while the others rotate 0,1,3.
  - `mid_alm_full=1` in cycle N → `pop=0` in N, while a push pending from N-1 still asserts.
- Reset mid-operation: assert `reset` in the cycle after `pop[1]`.
  - Next cycle: `push=0`.
  - After release: the first grant goes to class 0 (`ptr=0`).
  - Never two `pop` bits high in the same cycle.
